byte_cache: RTL

//  Direct-mapped, byte-line, write-through / no-write-allocate L1 cache downstream of the MIU.

---
 rtl/byte_cache.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/byte_cache.sv
// byte_cache: direct-mapped L1 cache with 1-byte lines, write-through and no write-allocate.
// One request is in flight at a time; misses and every store go out on the backing-memory port.
// Optional build macro CACHE_STATS_EN adds saturating load hit/miss counters (hit_count, miss_count).
module byte_cache #(
  parameter int ADDR_W    = 16,
  parameter int NUM_LINES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cache_req_valid,
  output logic              cache_req_ready,
  input  logic              cache_req_we,
  input  logic [ADDR_W-1:0] cache_req_addr,
  input  logic [7:0]        cache_req_write,
  output logic              cache_resp_valid,
  output logic [7:0]        cache_resp_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [7:0]        mem_req_wdata,
  input  logic              mem_resp_valid,
  input  logic [7:0]        mem_resp_data
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
`endif
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_W - IDX_W;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_LOOKUP   = 2'd1,
    S_MEM_REQ  = 2'd2,
    S_MEM_WAIT = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_nextState;

  logic               r_we;
  logic [ADDR_W-1:0]  r_addr;
  logic [7:0]         r_wdata;

  logic [NUM_LINES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag  [NUM_LINES];
  logic [7:0]         r_data [NUM_LINES];

  logic               r_respValid;
  logic [7:0]         r_respData;

  logic [IDX_W-1:0]   w_idx;
  logic [TAG_W-1:0]   w_tag;
  logic               w_hit;
  logic               w_accept;
  logic               w_loadHit;
  logic               w_fill;
  logic               w_memDone;

  assign w_idx     = r_addr[IDX_W-1:0];
  assign w_tag     = r_addr[ADDR_W-1:IDX_W];
  assign w_hit     = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_accept  = cache_req_valid && cache_req_ready;
  assign w_loadHit = (r_state == S_LOOKUP) && !r_we && w_hit;
  assign w_memDone = (r_state == S_MEM_WAIT) && mem_resp_valid;
  assign w_fill    = w_memDone && !r_we;

  // The memory request is driven straight from the latched request so it stays stable while stalled.
  assign mem_req_we       = r_we;
  assign mem_req_addr     = r_addr;
  assign mem_req_wdata    = r_wdata;
  assign cache_resp_valid = r_respValid;
  assign cache_resp_data  = r_respData;

  // State register; reset drops any transaction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_nextState;
  end

  // Next-state logic: load hits finish in LOOKUP, everything else goes through memory.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:     if (cache_req_valid) w_nextState = S_LOOKUP;
      S_LOOKUP:   w_nextState = w_loadHit ? S_IDLE : S_MEM_REQ;
      S_MEM_REQ:  if (mem_req_ready) w_nextState = S_MEM_WAIT;
      S_MEM_WAIT: if (mem_resp_valid) w_nextState = S_IDLE;
      default:    w_nextState = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state so reset removes mem_req_valid immediately.
  always_comb begin
    cache_req_ready = 1'b0;
    mem_req_valid   = 1'b0;
    case (r_state)
      S_IDLE:    cache_req_ready = 1'b1;
      S_MEM_REQ: mem_req_valid   = 1'b1;
      default:   ;
    endcase
  end

  // Capture the accepted request; it is held for the whole transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= 8'h00;
    end else if (w_accept) begin
      r_we    <= cache_req_we;
      r_addr  <= cache_req_addr;
      r_wdata <= cache_req_write;
    end
  end

  // Line valid bits: only a load fill sets a line valid, stores never allocate.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       r_valid        <= '0;
    else if (w_fill) r_valid[w_idx] <= 1'b1;
  end

  // Tag and data storage: fills write both, store hits refresh the data byte.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_tag[w_idx]  <= w_tag;
      r_data[w_idx] <= mem_resp_data;
    end else if ((r_state == S_LOOKUP) && r_we && w_hit) begin
      r_data[w_idx] <= r_wdata;
    end
  end

  // Response pulse; the data register only changes on load completions.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_respValid <= 1'b0;
      r_respData  <= 8'h00;
    end else begin
      r_respValid <= w_loadHit || w_memDone;
      if (w_loadHit)   r_respData <= r_data[w_idx];
      else if (w_fill) r_respData <= mem_resp_data;
    end
  end

`ifdef CACHE_STATS_EN
  logic [15:0] r_hitCount;
  logic [15:0] r_missCount;

  assign hit_count  = r_hitCount;
  assign miss_count = r_missCount;

  // Saturating load hit/miss counters, evaluated once per load in LOOKUP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hitCount  <= 16'h0000;
      r_missCount <= 16'h0000;
    end else if ((r_state == S_LOOKUP) && !r_we) begin
      if (w_hit) begin
        if (r_hitCount != 16'hFFFF) r_hitCount <= r_hitCount + 16'h0001;
      end else begin
        if (r_missCount != 16'hFFFF) r_missCount <= r_missCount + 16'h0001;
      end
    end
  end
`endif

endmodule
